// File: rtl/ca_pkg.sv
// Shared constants and state encoding for the C/A code receive path.
package ca_pkg;

  localparam int CHIPS_PER_CODE   = 1023;
  localparam int CODE_SHIFT_WIDTH = 10;
  localparam logic [CODE_SHIFT_WIDTH-1:0] LAST_CHIP   = CODE_SHIFT_WIDTH'(CHIPS_PER_CODE - 1);
  // Out-of-range index so the very first chip 0 after reset reads as a fresh boundary.
  localparam logic [CODE_SHIFT_WIDTH-1:0] SHIFT_RESET = LAST_CHIP + 10'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACCUM = 2'd2
  } ca_state_e;

endpackage

// File: rtl/ca_sat_accumulator.sv
// Signed despread-and-integrate cell: multiplies a sample by a +/-1 chip,
// then loads or saturating-adds it into a signed accumulator.
module ca_sat_accumulator #(
  parameter int SAMPLE_WIDTH = 4,
  parameter int ACC_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          add,
  input  logic                          code,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic signed [ACC_WIDTH-1:0]    acc,
  output logic                          sat
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] ext_s;
  logic signed [ACC_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH:0]   sum_s;
  logic signed [ACC_WIDTH-1:0] sum_sat_s;
  logic                        sat_s;
  logic signed [ACC_WIDTH-1:0] acc_r;

  // Product and saturating sum; widening before negation keeps -(-2^(W-1)) exact.
  always_comb begin
    ext_s     = {{(ACC_WIDTH-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
    prod_s    = code ? ext_s : -ext_s;
    sum_s     = {acc_r[ACC_WIDTH-1], acc_r} + {prod_s[ACC_WIDTH-1], prod_s};
    sum_sat_s = sum_s[ACC_WIDTH-1:0];
    sat_s     = 1'b0;
    if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
      sat_s     = 1'b1;
      sum_sat_s = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_s     = 1'b0;
      sum_sat_s = sum_s[ACC_WIDTH-1:0];
    end
  end

  // Accumulator register: load starts a new epoch, add integrates.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
    end else if (load) begin
      acc_r <= prod_s;
    end else if (add) begin
      acc_r <= sum_sat_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;
  assign sat = add & sat_s;

endmodule

// File: rtl/ca_epoch_correlator.sv
// Despreads I/Q samples against the local C/A chip stream and dumps one
// saturating I/Q sum, sample count and overflow flag per 1023-chip epoch.
module ca_epoch_correlator
  import ca_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int COUNT_WIDTH  = 14
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           sample_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_q,
  input  logic                           code_in,
  input  logic [CODE_SHIFT_WIDTH-1:0]    code_shift,
  output logic                           dump_valid,
  output logic signed [ACC_WIDTH-1:0]    acc_i,
  output logic signed [ACC_WIDTH-1:0]    acc_q,
  output logic [COUNT_WIDTH-1:0]         sample_count,
  output logic                           overflow,
  output logic                           busy
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  ca_state_e                     state_r;
  logic [CODE_SHIFT_WIDTH-1:0]   last_shift_r;
  logic [COUNT_WIDTH-1:0]        count_r;
  logic                          ovf_r;
  logic                          dump_valid_r;
  logic signed [ACC_WIDTH-1:0]   acc_i_r;
  logic signed [ACC_WIDTH-1:0]   acc_q_r;
  logic [COUNT_WIDTH-1:0]        sample_count_r;
  logic                          overflow_r;

  logic                          boundary_s;
  logic                          load_s;
  logic                          add_s;
  logic signed [ACC_WIDTH-1:0]   sum_i_s;
  logic signed [ACC_WIDTH-1:0]   sum_q_s;
  logic                          sat_i_s;
  logic                          sat_q_s;

  // Only the first sample of chip 0 opens an epoch, so several samples per chip are fine.
  assign boundary_s = sample_valid && (code_shift == 10'd0) && (last_shift_r != 10'd0);

  // Accumulator strobes; enable low suppresses any update of the partial epoch.
  always_comb begin
    load_s = 1'b0;
    add_s  = 1'b0;
    if (enable && boundary_s && ((state_r == ST_WAIT) || (state_r == ST_ACCUM))) begin
      load_s = 1'b1;
    end else if (enable && sample_valid && (state_r == ST_ACCUM)) begin
      add_s = 1'b1;
    end else begin
      load_s = 1'b0;
      add_s  = 1'b0;
    end
  end

  ca_sat_accumulator #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_acc_i (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .add    (add_s),
    .code   (code_in),
    .sample (sample_i),
    .acc    (sum_i_s),
    .sat    (sat_i_s)
  );

  ca_sat_accumulator #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_acc_q (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .add    (add_s),
    .code   (code_in),
    .sample (sample_q),
    .acc    (sum_q_s),
    .sat    (sat_q_s)
  );

  // Epoch FSM, sample counter, overflow tracking and dump registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      last_shift_r   <= SHIFT_RESET;
      count_r        <= '0;
      ovf_r          <= 1'b0;
      dump_valid_r   <= 1'b0;
      acc_i_r        <= '0;
      acc_q_r        <= '0;
      sample_count_r <= '0;
      overflow_r     <= 1'b0;
    end else begin
      dump_valid_r <= 1'b0;
      if (sample_valid) begin
        last_shift_r <= code_shift;
      end
      if (!enable) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_WAIT;
          end
          ST_WAIT: begin
            if (boundary_s) begin
              state_r <= ST_ACCUM;
              count_r <= COUNT_ONE;
              ovf_r   <= 1'b0;
            end
          end
          ST_ACCUM: begin
            if (boundary_s) begin
              acc_i_r        <= sum_i_s;
              acc_q_r        <= sum_q_s;
              sample_count_r <= count_r;
              overflow_r     <= ovf_r;
              dump_valid_r   <= 1'b1;
              count_r        <= COUNT_ONE;
              ovf_r          <= 1'b0;
            end else if (sample_valid) begin
              if (count_r != COUNT_MAX) begin
                count_r <= count_r + COUNT_ONE;
              end
              ovf_r <= ovf_r | sat_i_s | sat_q_s;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign dump_valid   = dump_valid_r;
  assign acc_i        = acc_i_r;
  assign acc_q        = acc_q_r;
  assign sample_count = sample_count_r;
  assign overflow     = overflow_r;
  assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ca_epoch_correlator.sv
// Directed bench for ca_epoch_correlator: a 16-bit and a 12-bit accumulator
// instance share one stimulus stream; expected sums are hand-computed.
module tb_ca_epoch_correlator;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              sample_valid;
  logic signed [3:0] sample_i;
  logic signed [3:0] sample_q;
  logic              code_in;
  logic [9:0]        code_shift;

  logic              dump_valid16, overflow16, busy16;
  logic signed [15:0] acc_i16, acc_q16;
  logic [13:0]       count16;
  logic              dump_valid12, overflow12, busy12;
  logic signed [11:0] acc_i12, acc_q12;
  logic [13:0]       count12;

  int n_cmp = 0;
  int n_err = 0;
  int dumps = 0;
  int dumps_mark = 0;

  always #5 clk = ~clk;

  ca_epoch_correlator #(.SAMPLE_WIDTH(4), .ACC_WIDTH(16), .COUNT_WIDTH(14)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .code_in(code_in), .code_shift(code_shift),
    .dump_valid(dump_valid16), .acc_i(acc_i16), .acc_q(acc_q16),
    .sample_count(count16), .overflow(overflow16), .busy(busy16)
  );

  ca_epoch_correlator #(.SAMPLE_WIDTH(4), .ACC_WIDTH(12), .COUNT_WIDTH(14)) dut12 (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .code_in(code_in), .code_shift(code_shift),
    .dump_valid(dump_valid12), .acc_i(acc_i12), .acc_q(acc_q12),
    .sample_count(count12), .overflow(overflow12), .busy(busy12)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] sh, input logic cd, input int si, input int sq);
    sample_valid = 1'b1;
    code_shift   = sh;
    code_in      = cd;
    sample_i     = si[3:0];
    sample_q     = sq[3:0];
    @(posedge clk);
    #1;
    if (dump_valid16) dumps++;
  endtask

  task automatic idle_cycle();
    sample_valid = 1'b0;
    code_shift   = 10'd0;
    code_in      = 1'($urandom);
    sample_i     = 4'($urandom);
    sample_q     = 4'($urandom);
    @(posedge clk);
    #1;
    if (dump_valid16) dumps++;
  endtask

  // mode 0: code_in = 1; mode 1: code_in = ~chip[0]
  task automatic run(input int first, input int last, input int spc, input int mode,
                     input int si, input int sq, input bit gaps);
    for (int c = first; c <= last; c++) begin
      for (int k = 0; k < spc; k++) begin
        step(10'(c), (mode != 0) ? ~c[0] : 1'b1, si, sq);
        if (gaps) idle_cycle();
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    sample_i = 4'sd0; sample_q = 4'sd0; code_in = 1'b0; code_shift = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dump_valid", 32'(dump_valid16), 0);
    chk("rst_acc_i", $signed(acc_i16), 0);
    chk("rst_acc_q", $signed(acc_q16), 0);
    chk("rst_count", 32'(count16), 0);
    chk("rst_overflow", 32'(overflow16), 0);
    chk("rst_busy", 32'(busy16), 0);
    reset = 1'b0;

    // Constant +1 code, I=+3 Q=-2: first epoch only arms, second is integrated.
    enable = 1'b1;
    run(0, 1022, 1, 0, 3, -2, 1'b0);
    chk("arm_busy", 32'(busy16), 1);
    run(0, 1022, 1, 0, 3, -2, 1'b0);
    chk("no_early_dump", dumps, 0);
    step(10'd0, 1'b1, 3, 0);
    chk("e1_dump_valid", 32'(dump_valid16), 1);
    chk("e1_acc_i", $signed(acc_i16), 3069);
    chk("e1_acc_q", $signed(acc_q16), -2046);
    chk("e1_count", 32'(count16), 1023);
    chk("e1_overflow", 32'(overflow16), 0);
    chk("e1_acc_i_w12", $signed(acc_i12), 2047);
    chk("e1_acc_q_w12", $signed(acc_q12), -2046);
    chk("e1_overflow_w12", 32'(overflow12), 1);

    // Alternating code with idle cycles between samples: 512*3 - 511*3 = 3.
    step(10'd1, 1'b0, 3, 0);
    chk("e1_pulse_width", 32'(dump_valid16), 0);
    idle_cycle();
    run(2, 1022, 1, 1, 3, 0, 1'b1);
    step(10'd0, 1'b1, 7, 0);
    chk("alt_dump_valid", 32'(dump_valid16), 1);
    chk("alt_acc_i", $signed(acc_i16), 3);
    chk("alt_acc_q", $signed(acc_q16), 0);
    chk("alt_count", 32'(count16), 1023);
    chk("alt_overflow_w12", 32'(overflow12), 0);

    // Positive, then negative saturation in the 12-bit instance, then a clean epoch.
    run(1, 1022, 1, 0, 7, 0, 1'b0);
    step(10'd0, 1'b1, -8, 0);
    chk("pos_acc_i", $signed(acc_i16), 7161);
    chk("pos_overflow", 32'(overflow16), 0);
    chk("pos_acc_i_w12", $signed(acc_i12), 2047);
    chk("pos_overflow_w12", 32'(overflow12), 1);
    run(1, 1022, 1, 0, -8, 0, 1'b0);
    step(10'd0, 1'b1, 1, 0);
    chk("neg_acc_i", $signed(acc_i16), -8184);
    chk("neg_acc_i_w12", $signed(acc_i12), -2048);
    chk("neg_overflow_w12", 32'(overflow12), 1);
    run(1, 1022, 1, 0, 1, 0, 1'b0);
    step(10'd0, 1'b1, 1, 0);
    chk("clean_acc_i_w12", $signed(acc_i12), 1023);
    chk("clean_overflow_w12", 32'(overflow12), 0);

    // Abort at chip 500, re-arm at chip 700.
    run(1, 499, 1, 0, 1, 0, 1'b0);
    dumps_mark = dumps;
    enable = 1'b0;
    step(10'd500, 1'b1, 1, 0);
    chk("abort_busy", 32'(busy16), 0);
    run(501, 699, 1, 0, 1, 0, 1'b0);
    chk("abort_hold_acc_i", $signed(acc_i16), 1023);
    chk("abort_hold_count", 32'(count16), 1023);
    enable = 1'b1;
    run(700, 1022, 1, 0, 2, 1, 1'b0);
    run(0, 1022, 1, 0, 2, 1, 1'b0);
    chk("rearm_no_dump", dumps - dumps_mark, 0);
    step(10'd0, 1'b1, 1, 0);
    chk("rearm_dump_valid", 32'(dump_valid16), 1);
    chk("rearm_acc_i", $signed(acc_i16), 2046);
    chk("rearm_acc_q", $signed(acc_q16), 1023);
    chk("rearm_count", 32'(count16), 1023);

    // Four samples per chip; only the first sample of chip 0 is a boundary.
    run(0, 0, 3, 0, 1, 0, 1'b0);
    run(1, 1022, 4, 0, 1, 0, 1'b0);
    step(10'd0, 1'b1, 1, 0);
    chk("spc4_dump_valid", 32'(dump_valid16), 1);
    chk("spc4_acc_i", $signed(acc_i16), 4092);
    chk("spc4_count", 32'(count16), 4092);
    chk("spc4_acc_i_w12", $signed(acc_i12), 2047);
    run(0, 0, 3, 0, 1, 0, 1'b0);
    run(1, 299, 4, 0, 1, 0, 1'b0);
    dumps_mark = dumps;
    reset = 1'b1;
    step(10'd300, 1'b1, 1, 0);
    chk("midrst_dump_valid", 32'(dump_valid16), 0);
    chk("midrst_acc_i", $signed(acc_i16), 0);
    chk("midrst_count", 32'(count16), 0);
    chk("midrst_busy", 32'(busy16), 0);
    reset = 1'b0;
    step(10'd301, 1'b1, 1, 0);
    chk("midrst_no_pulse", dumps - dumps_mark, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
